// File: rtl/ddma_cmd_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : ddma_cmd_arbiter
//  Description : Round-robin arbiter that lets NUM_REQ requesters share one
//                DDMA engine. Issues one start command per granted request,
//                supervises start and completion, and returns a done/err
//                pulse to the owning requester.
//  Revision    : 1.0  initial release
// ============================================================================
module ddma_cmd_arbiter #(
    parameter int NUM_REQ          = 4,
    parameter int MEMORY_BUS_WIDTH = 32,
    parameter int START_TIMEOUT    = 16,
    localparam int AW              = MEMORY_BUS_WIDTH - 2,
    localparam int IW              = $clog2(NUM_REQ)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req_valid_i,
    output logic [NUM_REQ-1:0]    req_ready_o,
    input  logic [NUM_REQ*AW-1:0] req_addr_i,
    input  logic [NUM_REQ*AW-1:0] req_nbytes_i,
    output logic [NUM_REQ-1:0]    done_o,
    output logic [NUM_REQ-1:0]    err_o,
    output logic [AW-1:0]         dma_addr_o,
    output logic [AW-1:0]         dma_nbytes_o,
    output logic                  dma_cmd_o,
    input  logic [4:0]            dma_status_i,
    input  logic [4:0]            dma_irq_i,
    output logic                  busy_o,
    output logic [IW-1:0]         grant_id_o
);

    localparam int CW = $clog2(START_TIMEOUT) + 1;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_ISSUE      = 3'd1,
        ST_WAIT_START = 3'd2,
        ST_WAIT_DONE  = 3'd3,
        ST_RESP       = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   last_grant_q, last_grant_d;
    logic [IW-1:0]   grant_id_q, grant_id_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [AW-1:0]   nbytes_q, nbytes_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            err_q, err_d;
    logic            arm_q, arm_d;

    logic [AW-1:0]   addr_arr   [NUM_REQ];
    logic [AW-1:0]   nbytes_arr [NUM_REQ];
    logic            win_found;
    logic [IW-1:0]   win_idx;
    logic [IW-1:0]   cand;
    logic            grant_en;
    logic            completion;
    logic            unused_bits;

    // Status bits 4:3 and interrupt bits 4:1 carry nothing this block needs.
    assign unused_bits = ^{dma_status_i[4:3], dma_irq_i[4:1]};

    // Split the flat request buses into per-requester fields.
    for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
        assign addr_arr[k]   = req_addr_i[k*AW +: AW];
        assign nbytes_arr[k] = req_nbytes_i[k*AW +: AW];
    end

    assign completion = dma_status_i[1] | dma_irq_i[0];

    // Round-robin search starting just after the most recent owner.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = IW'((int'(last_grant_q) + i) % NUM_REQ);
            if (!win_found && req_valid_i[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // arm_q keeps the first cycle after reset release free of grants.
    assign grant_en = reset && arm_q && (state_q == ST_IDLE) && win_found;

    // Outputs: strobes are gated by reset so nothing leaks while it is held.
    always_comb begin
        req_ready_o = '0;
        done_o      = '0;
        err_o       = '0;
        if (grant_en) begin
            req_ready_o[win_idx] = 1'b1;
        end
        if (reset && (state_q == ST_RESP)) begin
            done_o[grant_id_q] = 1'b1;
            err_o[grant_id_q]  = err_q;
        end
    end

    assign dma_cmd_o    = reset && (state_q == ST_ISSUE);
    assign busy_o       = reset && (state_q != ST_IDLE);
    assign dma_addr_o   = addr_q;
    assign dma_nbytes_o = nbytes_q;
    assign grant_id_o   = grant_id_q;

    // Next-state logic: grant, issue, supervise start/completion, respond.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_id_d   = grant_id_q;
        addr_d       = addr_q;
        nbytes_d     = nbytes_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
        arm_d        = 1'b1;
        case (state_q)
            ST_IDLE: begin
                if (grant_en) begin
                    grant_id_d = win_idx;
                    addr_d     = addr_arr[win_idx];
                    nbytes_d   = nbytes_arr[win_idx];
                    if (nbytes_arr[win_idx] == '0) begin
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end else begin
                        err_d   = 1'b0;
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                cnt_d   = '0;
                state_d = ST_WAIT_START;
            end
            ST_WAIT_START: begin
                if (completion) begin
                    err_d   = dma_status_i[2];
                    state_d = ST_RESP;
                end else if (dma_status_i[0]) begin
                    state_d = ST_WAIT_DONE;
                end else if (cnt_q == CW'(START_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                if (completion) begin
                    err_d   = dma_status_i[2];
                    state_d = ST_RESP;
                end else if (!dma_status_i[0]) begin
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                last_grant_d = grant_id_q;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            last_grant_q <= IW'(NUM_REQ - 1);
            grant_id_q   <= '0;
            addr_q       <= '0;
            nbytes_q     <= '0;
            cnt_q        <= '0;
            err_q        <= 1'b0;
            arm_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_id_q   <= grant_id_d;
            addr_q       <= addr_d;
            nbytes_q     <= nbytes_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            arm_q        <= arm_d;
        end
    end

endmodule
`default_nettype wire
